// File: rtl/pc_update_unit.sv
// pc_update_unit: program-counter stage of the 8-bit single-cycle CPU.
// Holds the architectural PC, computes the sequential and redirect targets,
// and freezes the PC while memory asserts busywait. The next-PC decision
// made on the edge that enters a stall is buffered in r_hold and applied
// on the edge where busywait falls.
// Optional build macro: PC_STALL_COUNT_EN enables a saturating stall-cycle
// counter on o_stallCount; without it the output is tied to zero.

module pc_update_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_offset,
    input  logic             i_jump,
    input  logic             i_branchEq,
    input  logic             i_branchNe,
    input  logic             i_zero,
    input  logic             i_busywait,
    output logic [31:0]      o_pc,
    output logic [31:0]      o_pcPlus4,
    output logic [31:0]      o_target,
    output logic             o_redirect,
    output logic             o_stalled,
    output logic [CNT_W-1:0] o_instrCount,
    output logic [CNT_W-1:0] o_stallCount
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [31:0]        r_pc;
    logic [31:0]        r_hold;
    logic [CNT_W-1:0]   r_instrCount;
    logic               r_stalled;
    logic [31:0]        w_pcPlus4;
    logic [31:0]        w_offsetWords;
    logic [31:0]        w_target;
    logic               w_redirect;
    logic [31:0]        w_nextPc;

    // Sequential and redirect targets; the shifted offset loses its top two bits.
    always_comb begin
        w_pcPlus4     = r_pc + 32'd4;
        w_offsetWords = i_offset << 2;
        w_target      = w_pcPlus4 + w_offsetWords;
        w_redirect    = i_jump | (i_branchEq & i_zero) | (i_branchNe & ~i_zero);
        w_nextPc      = w_redirect ? w_target : w_pcPlus4;
    end

    // State register; reset always returns to BOOT, discarding any stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: BOOT lasts one edge, RUN and STALL follow busywait.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT:    w_stateNext = RUN;
            RUN:     w_stateNext = i_busywait ? STALL : RUN;
            STALL:   w_stateNext = i_busywait ? STALL : RUN;
            default: w_stateNext = BOOT;
        endcase
    end

    // PC, hold buffer and retired-instruction counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_VECTOR;
            r_hold       <= 32'd0;
            r_instrCount <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (i_busywait) begin
                        r_hold <= w_nextPc;
                    end else begin
                        r_pc         <= w_nextPc;
                        r_instrCount <= r_instrCount + CNT_W'(1);
                    end
                end
                STALL: begin
                    if (!i_busywait) begin
                        r_pc         <= r_hold;
                        r_instrCount <= r_instrCount + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered stall flag, high exactly while the FSM sits in STALL.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stalled <= 1'b0;
        end else begin
            r_stalled <= (w_stateNext == STALL);
        end
    end

`ifdef PC_STALL_COUNT_EN
    logic [CNT_W-1:0] r_stallCount;

    // Saturating count of edges spent waiting on memory.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stallCount <= '0;
        end else if ((r_state == RUN || r_state == STALL) && i_busywait
                     && (r_stallCount != {CNT_W{1'b1}})) begin
            r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

    assign o_stallCount = r_stallCount;
`else
    assign o_stallCount = '0;
`endif

    assign o_pc         = r_pc;
    assign o_pcPlus4    = w_pcPlus4;
    assign o_target     = w_target;
    assign o_redirect   = w_redirect;
    assign o_stalled    = r_stalled;
    assign o_instrCount = r_instrCount;

endmodule

// File: tb/tb_pc_update_unit.sv
// tb_pc_update_unit: directed and randomized checks of pc_update_unit
// against a behavioural model of the PC stage.
// A narrow counter width keeps counter wrap and saturation reachable.

module tb_pc_update_unit;

    localparam int          CNT_W = 8;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic             clk;
    logic             reset;
    logic [31:0]      offset;
    logic             jump;
    logic             branchEq;
    logic             branchNe;
    logic             zero;
    logic             busywait;
    logic [31:0]      pc;
    logic [31:0]      pcPlus4;
    logic [31:0]      target;
    logic             redirect;
    logic             stalled;
    logic [CNT_W-1:0] instrCount;
    logic [CNT_W-1:0] stallCount;

    int checkCount;
    int failCount;

    // Model state: architectural PC, buffered decision and counters.
    logic [31:0]      mPc;
    logic [31:0]      mHold;
    bit               mBooting;
    bit               mStalled;
    logic [CNT_W-1:0] mInstr;
    logic [CNT_W-1:0] mStall;

    pc_update_unit #(
        .RESET_VECTOR(RV),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .i_offset(offset),
        .i_jump(jump),
        .i_branchEq(branchEq),
        .i_branchNe(branchNe),
        .i_zero(zero),
        .i_busywait(busywait),
        .o_pc(pc),
        .o_pcPlus4(pcPlus4),
        .o_target(target),
        .o_redirect(redirect),
        .o_stalled(stalled),
        .o_instrCount(instrCount),
        .o_stallCount(stallCount)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit jmp, input bit beq,
                                 input bit bne, input bit zf, input bit busy,
                                 input logic [31:0] off);
        reset    = rst;
        jump     = jmp;
        branchEq = beq;
        branchNe = bne;
        zero     = zf;
        busywait = busy;
        offset   = off;
    endtask

    // One clock: check combinational outputs, advance model and DUT, check state.
    task automatic step();
        logic [31:0] expPlus4;
        logic [31:0] expTarget;
        bit          expRedirect;
        logic [31:0] expNext;
        logic [31:0] expStallCnt;
        #1;
        expPlus4    = mPc + 32'd4;
        expTarget   = expPlus4 + (offset * 32'd4);
        expRedirect = jump || (branchEq && zero) || (branchNe && !zero);
        expNext     = expRedirect ? expTarget : expPlus4;
        checkOutput("pcPlus4", pcPlus4, expPlus4);
        checkOutput("target", target, expTarget);
        checkOutput("redirect", {31'd0, redirect}, {31'd0, expRedirect});

        if (reset) begin
            mPc = RV; mHold = 32'd0; mBooting = 1; mStalled = 0;
            mInstr = '0; mStall = '0;
        end else if (mBooting) begin
            mBooting = 0;
        end else if (mStalled) begin
            if (busywait) begin
                if (mStall != {CNT_W{1'b1}}) mStall = mStall + 1'b1;
            end else begin
                mPc = mHold; mInstr = mInstr + 1'b1; mStalled = 0;
            end
        end else begin
            if (busywait) begin
                mHold = expNext; mStalled = 1;
                if (mStall != {CNT_W{1'b1}}) mStall = mStall + 1'b1;
            end else begin
                mPc = expNext; mInstr = mInstr + 1'b1;
            end
        end

        @(posedge clk);
        #1;
`ifdef PC_STALL_COUNT_EN
        expStallCnt = 32'(mStall);
`else
        expStallCnt = 32'd0;
`endif
        checkOutput("pc", pc, mPc);
        checkOutput("stalled", {31'd0, stalled}, {31'd0, mStalled});
        checkOutput("instrCount", 32'(instrCount), 32'(mInstr));
        checkOutput("stallCount", 32'(stallCount), expStallCnt);
    endtask

    // Jump from the model's current PC to an arbitrary word address.
    task automatic gotoPc(input logic [31:0] dest);
        logic [31:0] off;
        off = (dest - mPc - 32'd4) >> 2;
        applyStimulus(0, 1, 0, 0, 0, 0, off);
        step();
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 32'd0);
        step();
        step();
        applyStimulus(0, 0, 0, 0, 0, 0, 32'd0);
        step();
    endtask

    initial begin
        logic [CNT_W-1:0] instrBefore;
        logic [CNT_W-1:0] stallBefore;
        int               guard;
        checkCount = 0;
        failCount  = 0;
        mPc = RV; mHold = 32'd0; mBooting = 1; mStalled = 0; mInstr = '0; mStall = '0;
        applyStimulus(1, 0, 0, 0, 0, 0, 32'd0);

        // Reset and boot: PC held at the vector, then one sequential retire.
        step();
        step();
        checkOutput("resetPc", pc, RV);
        checkOutput("resetInstr", 32'(instrCount), 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h55);
        step();
        checkOutput("bootPc", pc, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'd0);
        step();
        checkOutput("firstRetirePc", pc, 32'h4);
        checkOutput("firstRetireCnt", 32'(instrCount), 32'd1);

        // Backward beq taken and not taken.
        gotoPc(32'h10);
        applyStimulus(0, 0, 1, 0, 1, 0, 32'hFFFF_FFFE);
        #1;
        checkOutput("beqTarget", target, 32'h0C);
        checkOutput("beqRedirect", {31'd0, redirect}, 32'd1);
        step();
        checkOutput("beqTakenPc", pc, 32'h0C);
        gotoPc(32'h10);
        applyStimulus(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFE);
        step();
        checkOutput("beqNotTakenPc", pc, 32'h14);

        // bne taken, then jump.
        gotoPc(32'h20);
        applyStimulus(0, 0, 0, 1, 0, 0, 32'd3);
        step();
        checkOutput("bnePc", pc, 32'h30);
        applyStimulus(0, 1, 0, 0, 0, 0, 32'h7F);
        step();
        checkOutput("jumpPc", pc, 32'h230);

        // Jump combined with a taken branch still lands on the target.
        applyStimulus(0, 1, 1, 0, 1, 0, 32'd2);
        step();
        checkOutput("jumpBranchPc", pc, 32'h23C);

        // Stall buffering: decision captured on entry, later inputs ignored.
        gotoPc(32'h40);
        instrBefore = instrCount;
        stallBefore = stallCount;
        applyStimulus(0, 1, 0, 0, 0, 1, 32'd1);
        step();
        applyStimulus(0, 0, 0, 1, 1, 1, 32'd9);
        step();
        applyStimulus(0, 0, 1, 0, 1, 1, 32'h123);
        step();
        checkOutput("stallPc", pc, 32'h40);
        checkOutput("stallFlag", {31'd0, stalled}, 32'd1);
        checkOutput("stallInstrHeld", 32'(instrCount), 32'(instrBefore));
        applyStimulus(0, 0, 0, 0, 0, 0, 32'd0);
        step();
        checkOutput("stallReleasePc", pc, 32'h48);
        checkOutput("stallRetireOne", 32'(instrCount), 32'(instrBefore + 1'b1));
`ifdef PC_STALL_COUNT_EN
        checkOutput("stallCycles", 32'(stallCount - stallBefore), 32'd3);
`else
        checkOutput("stallCycles", 32'(stallCount - stallBefore), 32'd0);
`endif

        // Reset mid-stall discards the buffered target.
        gotoPc(32'hFC);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'd0);
        step();
        applyStimulus(1, 0, 0, 0, 0, 1, 32'd0);
        step();
        checkOutput("midStallResetPc", pc, RV);
        checkOutput("midStallResetFlag", {31'd0, stalled}, 32'd0);
        checkOutput("midStallResetCnt", 32'(instrCount), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'd0);
        step();
        checkOutput("postResetBootPc", pc, RV);
        step();
        checkOutput("postResetRunPc", pc, RV + 32'd4);

        // PC wrap at the top of the address space.
        gotoPc(32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'd0);
        step();
        checkOutput("pcWrap", pc, 32'h0);

        // Retired-instruction counter wrap.
        guard = 0;
        while (mInstr != {CNT_W{1'b1}} && guard < 600) begin
            step();
            guard++;
        end
        checkOutput("instrAllOnes", 32'(instrCount), 32'(2 ** CNT_W - 1));
        step();
        checkOutput("instrWrap", 32'(instrCount), 32'd0);

        // Randomized traffic, including stalls long enough to saturate.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] off;
            off = ($urandom_range(0, 1) == 1) ? $urandom
                                             : 32'($signed($urandom_range(0, 63)) - 32);
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1),
                          (i >= 1000 && i < 1400) ? 1'b1 : ($urandom_range(0, 9) < 3),
                          off);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage of the 8-bit single-cycle CPU. It consumes the 32-bit sign-extended branch/jump offset produced by the offset sign-extension stage.
- Computes sequential and redirect targets and holds the architectural PC.
- Freezes the PC while instruction or data memory asserts BUSYWAIT, buffering the next-PC decision across the stall.
- Feeds PC to instruction memory and PC_PLUS4 to the register-file write path.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter (and of the optional stall counter).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- OFFSET  input  32  sign-extended word offset from the sign-extension stage.
- JUMP  input  1  unconditional redirect (j).
- BRANCH_EQ  input  1  beq decoded.
- BRANCH_NE  input  1  bne decoded.
- ZERO  input  1  ALU zero flag.
- BUSYWAIT  input  1  memory stall request (OR of imem/dmem busywait).
- PC  output  32  current PC, registered.
- PC_PLUS4  output  32  PC + 4, combinational.
- TARGET  output  32  PC_PLUS4 + (OFFSET << 2), combinational.
- REDIRECT  output  1  JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO), combinational.
- STALLED  output  1  high while FSM is in STALL.
- INSTR_COUNT  output  CNT_W  retired-instruction count.
- STALL_COUNT  output  CNT_W  stall-cycle count (optional feature; see below).

Behaviour:
- Clock and reset: one clock CLK; reset RESET is synchronous and active-high. RESET has priority over all other inputs.
- Reset values: PC = RESET_VECTOR, INSTR_COUNT = 0, STALL_COUNT = 0, HOLD = 0, state = BOOT, STALLED = 0.
- Arithmetic: all 32-bit, modulo 2^32, with wrap-around and no overflow flag. OFFSET << 2 drops the top 2 bits.
- next_pc = REDIRECT ? TARGET : PC_PLUS4.
- If JUMP and a branch are both asserted, the redirect is still TARGET (same target).
- FSM states: BOOT, RUN, STALL.
- BOOT: the first edge after RESET falls holds PC at RESET_VECTOR so imem can fetch, then moves to RUN. Inputs are ignored and INSTR_COUNT is not incremented.
- RUN, BUSYWAIT=0: PC <= next_pc, INSTR_COUNT += 1, stay in RUN. Latency: one edge from decision to new PC.
- RUN, BUSYWAIT=1: PC holds, HOLD <= next_pc (sampled this edge), go to STALL.
- STALL, BUSYWAIT=1: PC and HOLD hold. JUMP/BRANCH_*/ZERO/OFFSET changes are ignored.
- STALL, BUSYWAIT=0: PC <= HOLD, INSTR_COUNT += 1, go to RUN.
- A stall of N cycles (BUSYWAIT high for N edges, starting in RUN) retires exactly one instruction, on the edge where BUSYWAIT is low.
- STALLED = (state == STALL), registered.
- RESET during STALL: HOLD is discarded and the FSM returns to BOOT with PC = RESET_VECTOR.
- Counter wrap: INSTR_COUNT all-ones + 1 -> 0.
- Combinational outputs track the current PC and inputs in all states, including during stall.

Optional Feature:
- Macro: PC_STALL_COUNT_EN.
- Defined: STALL_COUNT increments on every edge where the state is RUN or STALL and BUSYWAIT=1. It saturates at all-ones (no wrap) and clears on RESET.
- Undefined: no counter register is instantiated; STALL_COUNT is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset/boot: RESET=1 for 2 edges, then 0. PC=0 at edge 1 after release; PC=4 and INSTR_COUNT=1 after edge 2 (no redirect).
- Backward beq: PC=0x10, OFFSET=32'hFFFF_FFFE, BRANCH_EQ=1, ZERO=1 -> TARGET=0x0C, REDIRECT=1; PC=0x0C after edge. Same inputs with ZERO=0 -> PC=0x14.
- bne and jump: PC=0x20, BRANCH_NE=1, ZERO=0, OFFSET=3 -> PC=0x30. Then JUMP=1, OFFSET=0x7F -> PC=0x30+4+0x1FC=0x230.
- Stall buffering: PC=0x40, JUMP=1, OFFSET=1, BUSYWAIT=1 for 3 edges. Change JUMP to 0 mid-stall -> PC stays 0x40 and STALLED=1 for 3 cycles; on BUSYWAIT=0, PC=0x48 and INSTR_COUNT +1 only. With PC_STALL_COUNT_EN, STALL_COUNT=3.
- Reset mid-stall: enter STALL with HOLD=0x100, assert RESET -> PC=RESET_VECTOR, STALLED=0, INSTR_COUNT=0; HOLD is never loaded into PC.
- Wrap: PC=32'hFFFF_FFFC, no redirect -> PC=0. Force INSTR_COUNT to all-ones, retire one -> INSTR_COUNT=0.
